// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// rr_arb_mux : registered N-channel valid/ready mux with round-robin or forced select
// Revision   : 1.0
// ============================================================================
module rr_arb_mux #(
  parameter  int WIDTH = 32,
  parameter  int CH    = 4,
  localparam int SELW  = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       in_valid,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic [CH-1:0]       in_ready,
  input  logic                force_en,
  input  logic [SELW-1:0]     force_sel,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic [SELW-1:0]     out_sel,
  input  logic                out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             w_load;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt_idx;
  logic [SELW-1:0]  w_cand;

  assign w_load = !out_valid_q || out_ready;

  // Scan offsets high to low so the closest valid channel after ptr wins last.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    if (force_en) begin
      w_gnt_vld = in_valid[force_sel];
      w_gnt_idx = force_sel;
    end else begin
      for (int k = CH - 1; k >= 0; k--) begin
        w_cand = ptr_q + SELW'(k);
        if (in_valid[w_cand]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end
  end

  assign in_ready = (!rst && w_load && w_gnt_vld) ? (CH'(1) << w_gnt_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (w_load) begin
      out_valid_d = w_gnt_vld;
      if (w_gnt_vld) begin
        out_data_d = in_data[w_gnt_idx*WIDTH +: WIDTH];
        out_sel_d  = w_gnt_idx;
        ptr_d      = w_gnt_idx + SELW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// tb_rr_arb_mux : directed self-checking bench for rr_arb_mux (CH=4, WIDTH=32)
// Revision      : 1.0
// ============================================================================
module tb_rr_arb_mux;

  localparam int WIDTH = 32;
  localparam int CH    = 4;

  logic                clk;
  logic                rst;
  logic [CH-1:0]       in_valid;
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_ready;
  logic                force_en;
  logic [1:0]          force_sel;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;
  logic [1:0]          out_sel;
  logic                out_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] c_dat [CH];

  rr_arb_mux #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle away from it; inputs change only here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".sel"},   {30'd0, out_sel},   {30'd0, s});
    chk({tag, ".data"},  out_data, d);
  endtask

  initial begin
    c_dat[0] = 32'h0000_0000;
    c_dat[1] = 32'h0000_0001;
    c_dat[2] = 32'hAAAA_AAAA;
    c_dat[3] = 32'h8000_0001;
    in_data   = {c_dat[3], c_dat[2], c_dat[1], c_dat[0]};
    in_valid  = 4'b1111;
    rst       = 1'b1;
    force_en  = 1'b0;
    force_sel = 2'd0;
    out_ready = 1'b1;

    // Reset held two cycles with every channel requesting
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out("rst", 1'b0, 2'd0, 32'h0);
      chk("rst.in_ready", {28'd0, in_ready}, 32'h0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", {28'd0, in_ready}, 32'h1);

    // Round-robin saturation
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out("rr", 1'b1, 2'(i % 4), c_dat[i % 4]);
    end

    // Sparse requests: grant ch2 to park ptr at 3, then only ch1/ch3 valid
    in_valid = 4'b0100;
    step();
    chk_out("park", 1'b1, 2'd2, c_dat[2]);
    chk("park.ptr", {30'd0, dut.ptr_q}, 32'd3);
    in_valid = 4'b1010;
    step();
    chk_out("sparse0", 1'b1, 2'd3, c_dat[3]);
    step();
    chk_out("sparse1", 1'b1, 2'd1, c_dat[1]);
    step();
    chk_out("sparse2", 1'b1, 2'd3, c_dat[3]);

    // Backpressure with 0xAAAAAAAA held in the output register
    in_valid = 4'b0100;
    step();
    chk_out("bp_load", 1'b1, 2'd2, c_dat[2]);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    chk("bp.in_ready0", {28'd0, in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("bp_hold", 1'b1, 2'd2, c_dat[2]);
      chk("bp.in_ready", {28'd0, in_ready}, 32'h0);
      chk("bp.ptr", {30'd0, dut.ptr_q}, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel.in_ready", {28'd0, in_ready}, 32'h8);
    step();
    chk_out("bp_rel", 1'b1, 2'd3, c_dat[3]);

    // Forced mode steps through every channel
    force_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      force_sel = 2'(s);
      step();
      chk_out("force", 1'b1, 2'(s), c_dat[s]);
    end
    force_sel = 2'd2;
    in_valid  = 4'b1011;
    #1;
    chk("force_miss.in_ready", {28'd0, in_ready}, 32'h0);
    step();
    chk_out("force_miss", 1'b0, 2'd3, c_dat[3]);
    chk("force_miss.ptr", {30'd0, dut.ptr_q}, 32'd0);

    // Reset arriving while a beat is stalled
    force_en = 1'b0;
    in_valid = 4'b1111;
    step();
    chk_out("mid0", 1'b1, 2'd0, c_dat[0]);
    step();
    chk_out("mid1", 1'b1, 2'd1, c_dat[1]);
    out_ready = 1'b0;
    step();
    chk_out("mid_stall", 1'b1, 2'd1, c_dat[1]);
    rst = 1'b1;
    #1;
    chk("mid_rst.in_ready", {28'd0, in_ready}, 32'h0);
    step();
    chk_out("mid_rst", 1'b0, 2'd0, 32'h0);
    chk("mid_rst.ptr", {30'd0, dut.ptr_q}, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("after.in_ready", {28'd0, in_ready}, 32'h1);
    step();
    chk_out("after", 1'b1, 2'd0, c_dat[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
